cache_fill_ctrl: RTL

- Multi-cycle block-fill controller for the next WISC core generation, which adds instruction and data caches in front of a pipelined main memory.
- Arbitrates between an I-cache miss channel and a D-cache miss channel, and issues one word read per cycle for a whole block.
- Steers returned words into the winning cache's data array, then writes its tag and pulses a per-channel done.
- Parametrised in data width, address width and words per block.

---
 rtl/cache_fill_ctrl.sv | 109 ++++++++++
 1 files changed

// File: rtl/cache_fill_ctrl.sv
// Block-fill controller: arbitrates I/D cache misses, streams one word read per
// cycle for a whole block, steers returned words into the winning cache, then writes its tag.
module cache_fill_ctrl #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 16,
  parameter int WORDS  = 8,
  localparam int WIDX  = $clog2(WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_miss,
  input  logic [AWIDTH-1:0] i_miss_addr,
  input  logic              d_miss,
  input  logic [AWIDTH-1:0] d_miss_addr,
  output logic              mem_en,
  output logic [AWIDTH-1:0] mem_addr,
  input  logic              mem_data_valid,
  input  logic [DWIDTH-1:0] mem_data,
  output logic              fill_we,
  output logic              fill_sel,
  output logic [WIDX-1:0]   fill_word,
  output logic [DWIDTH-1:0] fill_data,
  output logic              tag_we,
  output logic              i_fill_done,
  output logic              d_fill_done,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_t;

  // Block base alignment: words are 2 bytes, so clear clog2(WORDS*2) low bits.
  localparam logic [AWIDTH-1:0] ALIGN = ~(AWIDTH'(WORDS * 2 - 1));
  localparam logic [WIDX-1:0]   LAST  = WIDX'(WORDS - 1);

  state_t            state, state_nx;
  logic [WIDX-1:0]   k, r;
  logic              sel, last_served;
  logic [AWIDTH-1:0] base;
  logic              win_d, recv;

  // Tie goes to the channel that was not served last (last_served: 0=I, 1=D).
  assign win_d = d_miss && (!i_miss || !last_served);
  assign recv  = mem_data_valid && (state == FILL || state == DRAIN);

  always_comb begin
    state_nx    = state;
    mem_en      = 1'b0;
    mem_addr    = '0;
    fill_we     = 1'b0;
    fill_sel    = 1'b0;
    fill_word   = '0;
    fill_data   = '0;
    tag_we      = 1'b0;
    i_fill_done = 1'b0;
    d_fill_done = 1'b0;
    busy        = (state != IDLE);
    case (state)
      IDLE:  if (i_miss || d_miss) state_nx = FILL;
      FILL: begin
        mem_en   = 1'b1;
        mem_addr = base + AWIDTH'({k, 1'b0});
        if (k == LAST) state_nx = DRAIN;
      end
      DONE: begin
        tag_we      = 1'b1;
        fill_sel    = sel;
        i_fill_done = !sel;
        d_fill_done = sel;
        state_nx    = IDLE;
      end
      default: ;
    endcase
    // Returns are accepted in FILL too, so the last word can only finish the block there
    // if the memory latency were zero.
    if (recv) begin
      fill_we   = 1'b1;
      fill_word = r;
      fill_data = mem_data;
      fill_sel  = sel;
      if (r == LAST) state_nx = DONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      k           <= '0;
      r           <= '0;
      sel         <= 1'b0;
      last_served <= 1'b0;
      base        <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (i_miss || d_miss) begin
          sel  <= win_d;
          base <= (win_d ? d_miss_addr : i_miss_addr) & ALIGN;
          k    <= '0;
          r    <= '0;
        end
        FILL: k <= k + 1'b1;
        DONE: last_served <= sel;
        default: ;
      endcase
      if (recv) r <= r + 1'b1;
    end
  end

endmodule
